sprite_mover: RTL

Parametrised movement/draw engine for NUM_SPRITES independent square-or-rectangular sprites (player cursor, ducks) on the VGA framebuffer.
- Accepts one movement command at a time via valid/ready.
- Erases the addressed sprite's old footprint, applies a clamped move, then redraws it, driving the adapter's pixel-plot interface.
- Replaces per-sprite hand-coded datapaths with one block serving all sprites, with edge-hit reporting and an error flag for invalid ids.

---
 rtl/duck_gfx_pkg.sv | 27 ++
 rtl/sprite_scan.sv | 41 ++++
 rtl/sprite_mover.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/duck_gfx_pkg.sv
// Shared constants for the duck-hunt graphics blocks: opcodes, FSM encoding,
// palette entries and default framebuffer geometry.
package duck_gfx_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOP   = 3'd0;
  localparam op_t OP_LEFT  = 3'd1;
  localparam op_t OP_RIGHT = 3'd2;
  localparam op_t OP_UP    = 3'd3;
  localparam op_t OP_DOWN  = 3'd4;
  localparam op_t OP_HOME  = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERASE = 3'd1;
  localparam logic [2:0] ST_MOVE  = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/sprite_scan.sv
// Raster counter over a SPR_W x SPR_H footprint; sx runs fastest and the
// counter wraps to (0,0) after the final pixel.
module sprite_scan #(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int SXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  parameter int SYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  output logic [SXW-1:0] sx,
  output logic [SYW-1:0] sy,
  output logic           last
);

  localparam logic [SXW-1:0] SX_MAX = SXW'(SPR_W - 1);
  localparam logic [SYW-1:0] SY_MAX = SYW'(SPR_H - 1);

  assign last = (sx == SX_MAX) && (sy == SY_MAX);

  // scan position: cleared by start, advanced one pixel per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= {SXW{1'b0}};
      sy <= {SYW{1'b0}};
    end else if (start) begin
      sx <= {SXW{1'b0}};
      sy <= {SYW{1'b0}};
    end else if (step) begin
      if (sx == SX_MAX) begin
        sx <= {SXW{1'b0}};
        sy <= (sy == SY_MAX) ? {SYW{1'b0}} : sy + SYW'(1);
      end else begin
        sx <= sx + SXW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Erase / clamped-move / redraw engine shared by all sprites, driving the
// framebuffer adapter's pixel-plot port one pixel per cycle.
module sprite_mover
  import duck_gfx_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int SPR_W       = 4,
  parameter int SPR_H       = 4,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int STEP        = 1,
  parameter int HOME_X      = 78,
  parameter int HOME_Y      = 58,
  parameter int IDW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [IDW-1:0]            cmd_id,
  input  logic [2:0]                cmd_op,
  input  logic [3*NUM_SPRITES-1:0]  sprite_colour,
  output logic [XW-1:0]             x_out,
  output logic [YW-1:0]             y_out,
  output logic [2:0]                colour_out,
  output logic                      plot,
  output logic                      done,
  output logic                      edge_hit,
  output logic                      err,
  output logic [XW*NUM_SPRITES-1:0] pos_x,
  output logic [YW*NUM_SPRITES-1:0] pos_y
);

  localparam int SXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int SYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [XW-1:0] MAX_X   = XW'(SCREEN_W - SPR_W);
  localparam logic [YW-1:0] MAX_Y   = YW'(SCREEN_H - SPR_H);
  localparam logic [XW:0]   STEP_XW = (XW + 1)'(STEP);
  localparam logic [YW:0]   STEP_YW = (YW + 1)'(STEP);

  logic [2:0]     r_state;
  logic [2:0]     w_next_state;
  logic [IDW-1:0] r_id;
  op_t            r_op;
  logic           r_final;
  logic           r_edge;
  logic [XW-1:0]  r_pos_x [NUM_SPRITES];
  logic [YW-1:0]  r_pos_y [NUM_SPRITES];

  logic           w_hs;
  logic           w_id_ok;
  logic [IDW-1:0] w_sel;
  logic [XW-1:0]  w_cur_x;
  logic [YW-1:0]  w_cur_y;
  logic [2:0]     w_colour;
  logic [XW-1:0]  w_new_x;
  logic [YW-1:0]  w_new_y;
  logic           w_hit;
  logic           w_emit_erase;
  logic           w_emit_draw;
  logic           w_step;
  logic           w_start;
  logic [SXW-1:0] w_sx;
  logic [SYW-1:0] w_sy;
  logic           w_last;
  logic [XW-1:0]  w_base_x;
  logic [YW-1:0]  w_base_y;
  logic [XW-1:0]  w_pix_x;
  logic [YW-1:0]  w_pix_y;

  assign w_hs    = cmd_valid & cmd_ready;
  assign w_id_ok = ({1'b0, cmd_id} < (IDW + 1)'(NUM_SPRITES));
  assign w_sel   = (r_state == ST_IDLE) ? cmd_id : r_id;

  // The output stage is registered, so pixel k is computed one cycle before it
  // is shown; the counter therefore leads the displayed pixel by one.
  assign w_emit_erase = ((r_state == ST_IDLE) & w_hs & w_id_ok)
                      | ((r_state == ST_ERASE) & ~r_final);
  assign w_emit_draw  = (r_state == ST_MOVE) | ((r_state == ST_DRAW) & ~r_final);
  assign w_step       = w_emit_erase | w_emit_draw;
  assign w_start      = ~w_step;

  sprite_scan #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .SXW   (SXW),
    .SYW   (SYW)
  ) u_scan (
    .clk   (clk),
    .rst   (reset),
    .start (w_start),
    .step  (w_step),
    .sx    (w_sx),
    .sy    (w_sy),
    .last  (w_last)
  );

  // position and colour of the addressed sprite
  always_comb begin
    w_cur_x  = {XW{1'b0}};
    w_cur_y  = {YW{1'b0}};
    w_colour = COL_BLACK;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_cur_x  = (w_sel == IDW'(i)) ? r_pos_x[i] : w_cur_x;
      w_cur_y  = (w_sel == IDW'(i)) ? r_pos_y[i] : w_cur_y;
      w_colour = (w_sel == IDW'(i)) ? sprite_colour[3*i +: 3] : w_colour;
    end
  end

  // clamped move; edge is flagged whenever the sprite ends on the border it moved toward
  always_comb begin
    w_new_x = w_cur_x;
    w_new_y = w_cur_y;
    w_hit   = 1'b0;
    case (r_op)
      OP_LEFT: begin
        if ({1'b0, w_cur_x} >= STEP_XW) begin
          w_new_x = w_cur_x - XW'(STEP);
        end else begin
          w_new_x = {XW{1'b0}};
        end
        w_hit = (w_new_x == {XW{1'b0}});
      end
      OP_RIGHT: begin
        if (({1'b0, w_cur_x} + STEP_XW) > {1'b0, MAX_X}) begin
          w_new_x = MAX_X;
        end else begin
          w_new_x = w_cur_x + XW'(STEP);
        end
        w_hit = (w_new_x == MAX_X);
      end
      OP_UP: begin
        if ({1'b0, w_cur_y} >= STEP_YW) begin
          w_new_y = w_cur_y - YW'(STEP);
        end else begin
          w_new_y = {YW{1'b0}};
        end
        w_hit = (w_new_y == {YW{1'b0}});
      end
      OP_DOWN: begin
        if (({1'b0, w_cur_y} + STEP_YW) > {1'b0, MAX_Y}) begin
          w_new_y = MAX_Y;
        end else begin
          w_new_y = w_cur_y + YW'(STEP);
        end
        w_hit = (w_new_y == MAX_Y);
      end
      OP_HOME: begin
        w_new_x = XW'(HOME_X);
        w_new_y = YW'(HOME_Y);
      end
      default: begin
        w_hit = 1'b0;
      end
    endcase
  end

  // the first draw pixel is issued from MOVE, before the new position is stored
  assign w_base_x = (r_state == ST_MOVE) ? w_new_x : w_cur_x;
  assign w_base_y = (r_state == ST_MOVE) ? w_new_y : w_cur_y;
  assign w_pix_x  = w_base_x + XW'(w_sx);
  assign w_pix_y  = w_base_y + YW'(w_sy);

  // state sequencing
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next_state = w_id_ok ? ST_ERASE : ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ERASE: w_next_state = r_final ? ST_MOVE : ST_ERASE;
      ST_MOVE:  w_next_state = ST_DRAW;
      ST_DRAW:  w_next_state = r_final ? ST_DONE : ST_DRAW;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // control state and registered pixel/handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_id       <= {IDW{1'b0}};
      r_op       <= OP_NOP;
      r_final    <= 1'b0;
      r_edge     <= 1'b0;
      cmd_ready  <= 1'b1;
      plot       <= 1'b0;
      x_out      <= {XW{1'b0}};
      y_out      <= {YW{1'b0}};
      colour_out <= COL_BLACK;
      done       <= 1'b0;
      edge_hit   <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      cmd_ready  <= (w_next_state == ST_IDLE);
      r_final    <= w_step & w_last;
      plot       <= w_step;
      x_out      <= w_step ? w_pix_x : {XW{1'b0}};
      y_out      <= w_step ? w_pix_y : {YW{1'b0}};
      colour_out <= w_emit_draw ? w_colour : COL_BLACK;
      done       <= (w_next_state == ST_DONE);
      edge_hit   <= (w_next_state == ST_DONE) & (r_state == ST_DRAW) & r_edge;
      err        <= (w_next_state == ST_DONE) & (r_state == ST_IDLE);
      if ((r_state == ST_IDLE) && w_hs) begin
        r_id <= cmd_id;
        r_op <= cmd_op;
      end
      if (r_state == ST_MOVE) begin
        r_edge <= w_hit;
      end
    end
  end

  // sprite positions, written only when leaving MOVE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pos_x[i] <= XW'(HOME_X);
        r_pos_y[i] <= YW'(HOME_Y);
      end
    end else if (r_state == ST_MOVE) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (r_id == IDW'(i)) begin
          r_pos_x[i] <= w_new_x;
          r_pos_y[i] <= w_new_y;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pos
    assign pos_x[g*XW +: XW] = r_pos_x[g];
    assign pos_y[g*YW +: YW] = r_pos_y[g];
  end

endmodule
